// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } mem_state_t;

    localparam logic [1:0] RESULT_ALU  = 2'b00;
    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] RESULT_PC4  = 2'b10;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // M stage holds the younger result, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
        if (m_hit) begin
            return FWD_M;
        end else if (w_hit) begin
            return FWD_W;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory req/ack sequencer with timeout; ERROR is sticky until reset.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MemAccessM,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_stall,
    output logic mem_err
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT - 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_req    = 1'b0;
        mem_err    = 1'b0;
        case (state_q)
            IDLE: begin
                mem_req = MemAccessM;
                // A same-cycle ack is a zero-wait access and never leaves IDLE.
                if (MemAccessM && !mem_ack) begin
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == CNT_MAX) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ERROR: begin
                mem_err = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_stall = (mem_req && !mem_ack) || mem_err;
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush/forward controller for the 5-stage pipeline.
// Optional perf counters (stall_cycles, flush_events) when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = 3,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned PERF_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic [1:0]            ResultSrcE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  PCSrcE,
    input  logic                  MemAccessM,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic                  mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]     stall_cycles,
    output logic [PERF_W-1:0]     flush_events
`endif
);

    if (MEM_TIMEOUT < 2 || PERF_W < 1) begin : g_bad_param
        $error("hazard_control_unit: MEM_TIMEOUT must be >= 2 and PERF_W >= 1");
    end

    logic m_valid, w_valid;
    logic lw_stall, mem_stall;

    assign m_valid = RegWriteM && (RdM != '0);
    assign w_valid = RegWriteW && (RdW != '0);

    assign ForwardAE = fwd_sel(m_valid && (RdM == Rs1E), w_valid && (RdW == Rs1E));
    assign ForwardBE = fwd_sel(m_valid && (RdM == Rs2E), w_valid && (RdW == Rs2E));

    assign lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemAccessM(MemAccessM),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_stall (mem_stall),
        .mem_err   (mem_err)
    );

    // A memory stall freezes the whole pipe and masks branch/load-use flushes.
    assign StallF = lw_stall || mem_stall;
    assign StallD = lw_stall || mem_stall;
    assign StallE = mem_stall;
    assign StallM = mem_stall;
    assign FlushW = mem_stall;
    assign FlushD = PCSrcE && !mem_stall;
    assign FlushE = (lw_stall || PCSrcE) && !mem_stall;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (StallF && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
            if (FlushE && (flush_events != '1)) begin
                flush_events <= flush_events + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit.
module tb_hazard_control_unit;

    localparam int unsigned MEM_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ack;
    logic       mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles, flush_events;
`endif

    always #5 clk = ~clk;

    hazard_control_unit #(
        .REG_ADDR_W (3),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .PERF_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE),
        .RdM       (RdM),
        .RdW       (RdW),
        .ResultSrcE(ResultSrcE),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .PCSrcE    (PCSrcE),
        .MemAccessM(MemAccessM),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .StallM    (StallM),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .FlushW    (FlushW),
        .mem_err   (mem_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
`endif
    );

    // Expected word: {FwdA[1:0], FwdB[1:0], StallF, StallD, StallE, StallM,
    //                 FlushD, FlushE, FlushW, mem_req, mem_err}
    localparam logic [12:0] W_IDLE  = 13'b00_00_0000_000_00;
    localparam logic [12:0] W_LW    = 13'b00_00_1100_010_00;
    localparam logic [12:0] W_PC    = 13'b00_00_0000_110_00;
    localparam logic [12:0] W_MEM   = 13'b00_00_1111_001_10;
    localparam logic [12:0] W_ACK   = 13'b00_00_0000_000_10;
    localparam logic [12:0] W_ERR   = 13'b00_00_1111_001_01;

    typedef struct {
        string       name;
        logic [2:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0]  rsrc;
        logic        rwm, rww, pcsrc;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edges;

    task automatic add_vec(input string name, input logic [2:0] rs1d, input logic [2:0] rs2d,
                           input logic [2:0] rs1e, input logic [2:0] rs2e, input logic [2:0] rde,
                           input logic [2:0] rdm, input logic [2:0] rdw, input logic [1:0] rsrc,
                           input logic rwm, input logic rww, input logic pcsrc,
                           input logic [12:0] exp);
        vec_t v;
        v.name = name; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rsrc = rsrc;
        v.rwm = rwm; v.rww = rww; v.pcsrc = pcsrc; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, mem_req, mem_err};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE = 2'b00; RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        MemAccessM = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check("reset", W_IDLE);
        #10 rst_n = 1'b1;

        //       name        rs1d rs2d rs1e rs2e rde  rdm  rdw  rsrc   rwm rww pc  exp
        add_vec("idle",      0,   0,   0,   0,   0,   0,   0,   2'b00, 0,  0,  0,  W_IDLE);
        add_vec("fwd_m_pri", 0,   0,   3,   0,   0,   3,   3,   2'b00, 1,  1,  0,  13'b10_00_0000_000_00);
        add_vec("fwd_w",     0,   0,   3,   0,   0,   3,   3,   2'b00, 0,  1,  0,  13'b01_00_0000_000_00);
        add_vec("fwd_x0_m",  0,   0,   0,   0,   0,   0,   0,   2'b00, 1,  0,  0,  W_IDLE);
        add_vec("fwd_x0_w",  0,   0,   0,   0,   0,   0,   0,   2'b00, 0,  1,  0,  W_IDLE);
        add_vec("fwd_split", 0,   0,   4,   5,   0,   4,   5,   2'b00, 1,  1,  0,  13'b10_01_0000_000_00);
        add_vec("fwd_b_m",   0,   0,   0,   6,   0,   6,   6,   2'b00, 1,  1,  0,  13'b00_10_0000_000_00);
        add_vec("fwd_nowr",  0,   0,   2,   2,   0,   2,   2,   2'b00, 0,  0,  0,  W_IDLE);
        add_vec("lw_rs2",    0,   2,   0,   0,   2,   0,   0,   2'b01, 0,  0,  0,  W_LW);
        add_vec("lw_rs1",    7,   0,   0,   0,   7,   0,   0,   2'b01, 0,  0,  0,  W_LW);
        add_vec("alu_nolw",  0,   2,   0,   0,   2,   0,   0,   2'b00, 0,  0,  0,  W_IDLE);
        add_vec("pc4_nolw",  2,   0,   0,   0,   2,   0,   0,   2'b10, 0,  0,  0,  W_IDLE);
        add_vec("lw_x0",     0,   0,   0,   0,   0,   0,   0,   2'b01, 0,  0,  0,  W_IDLE);
        add_vec("lw_nomatch",1,   3,   0,   0,   2,   0,   0,   2'b01, 0,  0,  0,  W_IDLE);
        add_vec("branch",    0,   0,   0,   0,   0,   0,   0,   2'b00, 0,  0,  1,  W_PC);
        add_vec("lw_branch", 0,   2,   0,   0,   2,   0,   0,   2'b01, 0,  0,  1,  13'b00_00_1100_110_00);

        foreach (vecs[i]) begin
            next_cycle();
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e;
            Rs2E = vecs[i].rs2e; RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            ResultSrcE = vecs[i].rsrc; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            PCSrcE = vecs[i].pcsrc;
            #4;
            check(vecs[i].name, vecs[i].exp);
        end
        clear_inputs();

        // Load-use stall lasts one cycle: the bubble then occupies E.
        next_cycle();
        ResultSrcE = 2'b01; RdE = 3'd2; Rs2D = 3'd2;
        #4 check("lw_seq_c0", W_LW);
        next_cycle();
        ResultSrcE = 2'b00; RdE = 3'd0;
        #4 check("lw_seq_c1", W_IDLE);
        clear_inputs();

        // Three-cycle memory wait, with branch/load-use masked mid-stall.
        next_cycle();
        MemAccessM = 1'b1;
        #4 check("mem_c0", W_MEM);
        next_cycle();
        ResultSrcE = 2'b01; RdE = 3'd2; Rs2D = 3'd2; PCSrcE = 1'b1;
        #4 check("mem_c1_masked", W_MEM);
        next_cycle();
        ResultSrcE = 2'b00; RdE = 3'd0; Rs2D = 3'd0; PCSrcE = 1'b0;
        #4 check("mem_c2", W_MEM);
        next_cycle();
        mem_ack = 1'b1;
        #4 check("mem_ack", W_ACK);
        next_cycle();
        MemAccessM = 1'b0; mem_ack = 1'b0;
        #4 check("mem_done", W_IDLE);
        next_cycle();
        PCSrcE = 1'b1;
        #4 check("mem_back_idle", W_PC);
        clear_inputs();

        // Zero-wait access: ack in the request cycle stays in IDLE.
        next_cycle();
        MemAccessM = 1'b1; mem_ack = 1'b1;
        #4 check("zero_wait", W_ACK);
        next_cycle();
        MemAccessM = 1'b0; mem_ack = 1'b0;
        #4 check("zero_wait_after", W_IDLE);

        // Timeout: one IDLE request cycle plus MEM_TIMEOUT WAIT cycles.
        next_cycle();
        MemAccessM = 1'b1;
        #4 check("to_req", W_MEM);
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            edges++;
            if (mem_err) break;
        end
        check_int("timeout_edges", edges, MEM_TIMEOUT + 1);
        #4 check("err_state", W_ERR);
        mem_ack = 1'b1;
        #1 check("err_ack_ignored", W_ERR);
        next_cycle();
        check("err_sticky", W_ERR);
        MemAccessM = 1'b0; mem_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("err_reset", W_IDLE);
        next_cycle();
        rst_n = 1'b1;
        #4 check("err_reset_rel", W_IDLE);

        // Asynchronous reset in the middle of WAIT drops mem_req immediately.
        next_cycle();
        MemAccessM = 1'b1;
        next_cycle();
        next_cycle();
        MemAccessM = 1'b0;
        #2 check("wait_hold", W_MEM);
        rst_n = 1'b0;
        #1 check("async_reset", W_IDLE);
        next_cycle();
        rst_n = 1'b1;
        #4 check("async_reset_rel", W_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
